// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the memory-mapped UART receiver: default timing and
// depth, register offsets within the 16-byte window, and receiver states.
package uart_rx_fifo_pkg;

    localparam int unsigned UART_CLK_DIVIDER_BIT = 173;
    localparam int unsigned UART_RX_FIFO_DEPTH   = 8;

    localparam logic [3:0] OFS_DATA = 4'h0;
    localparam logic [3:0] OFS_IRQ  = 4'h8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Core peripheral memory port as seen by the UART receiver.
interface uart_rx_fifo_if;

    // mem_valid is a one-cycle request; the slave answers with mem_ready high for
    // exactly one cycle, on the cycle after the request, with mem_rdata valid only
    // while mem_ready is high. mem_wstrb == 0 marks a read.
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/uart_rx_fifo_buf.sv
// Synchronous byte FIFO with wrap-bit pointers; a pop frees room for a push in
// the same cycle, so push-while-full is accepted when paired with a pop.
module uart_rx_fifo_buf #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with receive FIFO, data/irq registers and a level interrupt.
// Bit timing is measured in CPU clocks on the synchronised serial input.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER_BIT = UART_CLK_DIVIDER_BIT,
    parameter int unsigned FIFO_DEPTH      = UART_RX_FIFO_DEPTH
) (
    input  logic           clock,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus,
    input  logic           rx,
    output logic           irq,
    output rx_state_e      rx_state_dbg
);

    localparam int CW = $clog2(CLK_DIVIDER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIVIDER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIVIDER_BIT - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_req;
    logic          frame_evt;
    logic          cnt_zero;

    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic          pop;

    logic          irq_en_q, irq_en_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          irq_q;
    logic          ready_q;
    logic [31:0]   rdata_q, rdata_d;

    logic          is_read;
    logic [3:0]    offset;
    logic          rd_data, rd_irq, wr_irq;
    logic          overrun_evt;
    logic          unused_bus;

    assign unused_bus = ^{bus.mem_addr[31:4], bus.mem_wdata[31:1], bus.mem_wstrb[3:1]};

    // Synchroniser resets to idle-high so a reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx};
    end
    assign rx_s = sync_q[1];

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_evt = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    state_d = RX_IDLE;
                end else begin
                    cnt_d   = CNT_FULL;
                    bit_d   = 3'd0;
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    push_req = 1'b1;
                    state_d  = RX_IDLE;
                end else begin
                    frame_evt = 1'b1;
                    state_d   = RX_WAIT;
                end
            end
            RX_WAIT: begin
                // Hold off start detection until a break ends.
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign rx_state_dbg = state_q;

    assign is_read = (bus.mem_wstrb == 4'b0000);
    assign offset  = bus.mem_addr[3:0];
    assign rd_data = bus.mem_valid && is_read && (offset == OFS_DATA);
    assign rd_irq  = bus.mem_valid && is_read && (offset == OFS_IRQ);
    assign wr_irq  = bus.mem_valid && !is_read && (offset == OFS_IRQ) && bus.mem_wstrb[0];
    assign pop     = rd_data && !fifo_empty;

    // A pop in the same cycle makes room, so only an unpaired push into a full FIFO overruns.
    assign overrun_evt = push_req && fifo_full && !pop;

    uart_rx_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_buf (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_req),
        .pop_i   (pop),
        .din_i   (shift_q),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_comb begin
        irq_en_d    = wr_irq ? bus.mem_wdata[0] : irq_en_q;
        overrun_d   = overrun_evt ? 1'b1 : (rd_irq ? 1'b0 : overrun_q);
        frame_err_d = frame_evt   ? 1'b1 : (rd_irq ? 1'b0 : frame_err_q);
        rdata_d     = '0;
        if (bus.mem_valid && is_read) begin
            if (offset == OFS_DATA)
                rdata_d = {fifo_empty, 23'd0, fifo_empty ? 8'h00 : fifo_head};
            else if (offset == OFS_IRQ)
                rdata_d = {28'd0, frame_err_q, overrun_q, !fifo_empty, irq_en_q};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_en_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            irq_en_q    <= irq_en_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_en_q && (!fifo_empty || overrun_q || frame_err_q);
            ready_q     <= bus.mem_valid;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign irq           = irq_q;

endmodule
